// File: rtl/tile_pixel_renderer.sv
// rtl/tile_pixel_renderer.sv - 3-stage tile map / sprite to RGB pipeline with aligned syncs
// Optional: COIN_BLINK_EN makes coin tiles blink with frame_count[4].
module tile_pixel_renderer #(
    parameter int BDR             = 0,
    parameter int SKY             = 1,
    parameter int BLK             = 2,
    parameter int GND             = 3,
    parameter int TKN             = 4,
    parameter int CK1             = 5,
    parameter int CK2             = 6,
    parameter int CHARACTER_WIDTH = 42,
    parameter int SCREEN_WIDTH    = 640,
    parameter int SCREEN_HEIGHT   = 480,
    parameter int BLOCK_WIDTH     = 40
) (
    input  logic                      vga_clock,
    input  logic                      reset,
    input  logic [9:0]                pixel_x,
    input  logic [9:0]                pixel_y,
    input  logic                      pixel_valid,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic [11:0][16:0][7:0]    background,
    input  logic signed [31:0]        mario_x,
    input  logic signed [31:0]        mario_y,
    input  logic signed [31:0]        goomba_x,
    input  logic signed [31:0]        goomba_y,
    input  logic signed [31:0]        goomba_2x,
    input  logic signed [31:0]        goomba_2y,
    input  logic                      win,
    input  logic                      lose,
    output logic [7:0]                red,
    output logic [7:0]                green,
    output logic [7:0]                blue,
    output logic                      hsync_out,
    output logic                      vsync_out,
    output logic [15:0]               frame_count
);
    localparam logic [23:0] RGB_MARIO   = 24'hE40058;
    localparam logic [23:0] RGB_GOOMBA  = 24'h883800;
    localparam logic [23:0] RGB_GOOMBA2 = 24'hC07000;
    localparam logic [23:0] RGB_BDR     = 24'h000000;
    localparam logic [23:0] RGB_SKY     = 24'h5C94FC;
    localparam logic [23:0] RGB_BLK     = 24'hB84C0C;
    localparam logic [23:0] RGB_GND     = 24'h00A800;
    localparam logic [23:0] RGB_CK1     = 24'hFFFFFF;
    localparam logic [23:0] RGB_CK2     = 24'hC0C0C0;
    localparam logic [23:0] RGB_COIN    = 24'hFCD800;
    localparam logic [23:0] RGB_BAD     = 24'hFF00FF;
    localparam logic [23:0] RGB_WIN     = 24'h00FF00;

    function automatic logic in_box(input logic signed [31:0] p, input logic signed [31:0] s);
        return (p >= s) && (p <= s + (CHARACTER_WIDTH - 1));
    endfunction

    logic [9:0]         col_div, row_div;
    logic [9:0]         x1_d, x1_q, y1_d, y1_q;
    logic [4:0]         col1_d, col1_q;
    logic [3:0]         row1_d, row1_q;
    logic               off1_d, off1_q, valid1_d, valid1_q, hs1_d, hs1_q, vs1_d, vs1_q;

    logic signed [31:0] xs, ys;
    logic [9:0]         col_base, row_base;
    logic [7:0]         tile2_d, tile2_q;
    logic [9:0]         ox2_d, ox2_q, oy2_d, oy2_q, x2_d, x2_q, y2_d, y2_q;
    logic               mario_hit2_d, mario_hit2_q, goomba_hit2_d, goomba_hit2_q;
    logic               goomba2_hit2_d, goomba2_hit2_q;
    logic               valid2_d, valid2_q, hs2_d, hs2_q, vs2_d, vs2_q;
    logic               win2_d, win2_q, lose2_d, lose2_q;

    logic               coin_on;
    logic [23:0]        tile_rgb, mux_rgb, rgb3_d, rgb3_q;
    logic               hs3_d, hs3_q, vs3_d, vs3_q;
    logic               vs_prev_d, vs_prev_q;
    logic [15:0]        frame_count_d, frame_count_q;

    // S1: tile coordinates; off-map pixels get a safe (0,0) index and are forced to BDR later.
    always_comb begin
        col_div  = pixel_x / 10'(BLOCK_WIDTH);
        row_div  = pixel_y / 10'(BLOCK_WIDTH);
        off1_d   = (col_div > 10'd16) || (row_div > 10'd11);
        col1_d   = off1_d ? 5'd0 : col_div[4:0];
        row1_d   = off1_d ? 4'd0 : row_div[3:0];
        x1_d     = pixel_x;
        y1_d     = pixel_y;
        valid1_d = pixel_valid;
        hs1_d    = hsync_in;
        vs1_d    = vsync_in;
    end

    // S2: map lookup, in-tile offset and signed sprite box tests.
    always_comb begin
        xs             = {22'd0, x1_q};
        ys             = {22'd0, y1_q};
        col_base       = 10'(col1_q) * 10'(BLOCK_WIDTH);
        row_base       = 10'(row1_q) * 10'(BLOCK_WIDTH);
        tile2_d        = off1_q ? 8'(BDR) : background[row1_q][col1_q];
        ox2_d          = x1_q - col_base;
        oy2_d          = y1_q - row_base;
        mario_hit2_d   = valid1_q && in_box(xs, mario_x) && in_box(ys, mario_y);
        goomba_hit2_d  = valid1_q && in_box(xs, goomba_x) && in_box(ys, goomba_y);
        goomba2_hit2_d = valid1_q && in_box(xs, goomba_2x) && in_box(ys, goomba_2y);
        x2_d           = x1_q;
        y2_d           = y1_q;
        valid2_d       = valid1_q;
        hs2_d          = hs1_q;
        vs2_d          = vs1_q;
        win2_d         = win;
        lose2_d        = lose;
    end

    // S3: colour mux, overlays and blanking.
    always_comb begin
`ifdef COIN_BLINK_EN
        coin_on = (ox2_q >= 10'd8) && (ox2_q <= 10'd31) && (oy2_q >= 10'd8) && (oy2_q <= 10'd31)
                  && !frame_count_q[4];
`else
        coin_on = (ox2_q >= 10'd8) && (ox2_q <= 10'd31) && (oy2_q >= 10'd8) && (oy2_q <= 10'd31);
`endif
        case (tile2_q)
            8'(BDR): tile_rgb = RGB_BDR;
            8'(SKY): tile_rgb = RGB_SKY;
            8'(BLK): tile_rgb = RGB_BLK;
            8'(GND): tile_rgb = RGB_GND;
            8'(TKN): tile_rgb = coin_on ? RGB_COIN : RGB_SKY;
            8'(CK1): tile_rgb = RGB_CK1;
            8'(CK2): tile_rgb = RGB_CK2;
            default: tile_rgb = RGB_BAD;
        endcase

        if (mario_hit2_q)        mux_rgb = RGB_MARIO;
        else if (goomba_hit2_q)  mux_rgb = RGB_GOOMBA;
        else if (goomba2_hit2_q) mux_rgb = RGB_GOOMBA2;
        else                     mux_rgb = tile_rgb;

        if (!valid2_q)
            rgb3_d = 24'h000000;
        else if (lose2_q)
            rgb3_d = {8'hFF, 1'b0, mux_rgb[15:9], 1'b0, mux_rgb[7:1]};
        else if (win2_q && ((x2_q < 10'd4) || (x2_q >= 10'(SCREEN_WIDTH - 4)) ||
                            (y2_q < 10'd4) || (y2_q >= 10'(SCREEN_HEIGHT - 4))))
            rgb3_d = RGB_WIN;
        else
            rgb3_d = mux_rgb;

        hs3_d         = hs2_q;
        vs3_d         = vs2_q;
        vs_prev_d     = vsync_in;
        frame_count_d = (vs_prev_q && !vsync_in) ? frame_count_q + 16'd1 : frame_count_q;
    end

    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            x1_q           <= '0;
            y1_q           <= '0;
            col1_q         <= '0;
            row1_q         <= '0;
            off1_q         <= 1'b0;
            valid1_q       <= 1'b0;
            hs1_q          <= 1'b1;
            vs1_q          <= 1'b1;
            tile2_q        <= '0;
            ox2_q          <= '0;
            oy2_q          <= '0;
            x2_q           <= '0;
            y2_q           <= '0;
            mario_hit2_q   <= 1'b0;
            goomba_hit2_q  <= 1'b0;
            goomba2_hit2_q <= 1'b0;
            valid2_q       <= 1'b0;
            hs2_q          <= 1'b1;
            vs2_q          <= 1'b1;
            win2_q         <= 1'b0;
            lose2_q        <= 1'b0;
            rgb3_q         <= '0;
            hs3_q          <= 1'b1;
            vs3_q          <= 1'b1;
            vs_prev_q      <= 1'b1;
            frame_count_q  <= '0;
        end else begin
            x1_q           <= x1_d;
            y1_q           <= y1_d;
            col1_q         <= col1_d;
            row1_q         <= row1_d;
            off1_q         <= off1_d;
            valid1_q       <= valid1_d;
            hs1_q          <= hs1_d;
            vs1_q          <= vs1_d;
            tile2_q        <= tile2_d;
            ox2_q          <= ox2_d;
            oy2_q          <= oy2_d;
            x2_q           <= x2_d;
            y2_q           <= y2_d;
            mario_hit2_q   <= mario_hit2_d;
            goomba_hit2_q  <= goomba_hit2_d;
            goomba2_hit2_q <= goomba2_hit2_d;
            valid2_q       <= valid2_d;
            hs2_q          <= hs2_d;
            vs2_q          <= vs2_d;
            win2_q         <= win2_d;
            lose2_q        <= lose2_d;
            rgb3_q         <= rgb3_d;
            hs3_q          <= hs3_d;
            vs3_q          <= vs3_d;
            vs_prev_q      <= vs_prev_d;
            frame_count_q  <= frame_count_d;
        end
    end

    assign red         = rgb3_q[23:16];
    assign green       = rgb3_q[15:8];
    assign blue        = rgb3_q[7:0];
    assign hsync_out   = hs3_q;
    assign vsync_out   = vs3_q;
    assign frame_count = frame_count_q;

endmodule
